// File: rtl/argmax_pkg.sv
// Shared types for the argmax_tracker block.
package argmax_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/mag_cmp.sv
// Combinational magnitude comparator; exactly one of gt/lt/eq is high.
// Define ARGMAX_SIGNED_EN to compare a and b as two's complement.
module mag_cmp #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt,
  output logic              lt,
  output logic              eq
);

`ifdef ARGMAX_SIGNED_EN
  assign gt = $signed(a) > $signed(b);
  assign lt = $signed(a) < $signed(b);
`else
  assign gt = a > b;
  assign lt = a < b;
`endif
  assign eq = (a == b);

endmodule

// File: rtl/argmax_tracker.sv
// Streaming argmax over a frame of scores: reports winning index, max, tie and count.
// Signed scores are selected by defining ARGMAX_SIGNED_EN (default: unsigned).
module argmax_tracker
  import argmax_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int NUM_CLASS = 10,
  localparam int IDX_W     = $clog2(NUM_CLASS),
  localparam int CNT_W     = $clog2(NUM_CLASS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_max,
  output logic              out_tie,
  output logic [CNT_W-1:0]  out_count
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_run_max;
  logic [IDX_W-1:0]   r_run_idx;
  logic               r_run_tie;
  logic [IDX_W-1:0]   r_out_idx;
  logic [DATA_W-1:0]  r_out_max;
  logic               r_out_tie;
  logic [CNT_W-1:0]   r_out_count;

  logic               w_gt, w_lt, w_eq;
  logic               w_first, w_accept, w_term;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [DATA_W-1:0]  w_nxt_max;
  logic [IDX_W-1:0]   w_nxt_idx;
  logic               w_nxt_tie;

  mag_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a  (in_data),
    .b  (r_run_max),
    .gt (w_gt),
    .lt (w_lt),
    .eq (w_eq)
  );

  assign w_first   = (r_cnt == '0);
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_term    = w_accept && (in_last || (w_cnt_inc == CNT_W'(NUM_CLASS)));

  // Equal scores only raise tie, so the earliest index of the max is kept.
  assign w_nxt_max = (w_first || w_gt) ? in_data : r_run_max;
  assign w_nxt_idx = w_first ? '0 : (w_gt ? r_cnt[IDX_W-1:0] : r_run_idx);
  assign w_nxt_tie = (w_first || w_gt) ? 1'b0 : (w_eq ? 1'b1 : r_run_tie);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (!clear && w_term) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (clear || out_ready) w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_run_max   <= '0;
      r_run_idx   <= '0;
      r_run_tie   <= 1'b0;
      r_out_idx   <= '0;
      r_out_max   <= '0;
      r_out_tie   <= 1'b0;
      r_out_count <= '0;
    end else if (clear || (r_state == DONE && out_ready)) begin
      // Result registers hold their last value until the next frame loads them.
      r_cnt     <= '0;
      r_run_max <= '0;
      r_run_idx <= '0;
      r_run_tie <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= w_cnt_inc;
      r_run_max <= w_nxt_max;
      r_run_idx <= w_nxt_idx;
      r_run_tie <= w_nxt_tie;
      if (w_term) begin
        r_out_idx   <= w_nxt_idx;
        r_out_max   <= w_nxt_max;
        r_out_tie   <= w_nxt_tie;
        r_out_count <= w_cnt_inc;
      end
    end
  end

  assign out_idx   = r_out_idx;
  assign out_max   = r_out_max;
  assign out_tie   = r_out_tie;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_argmax_tracker.sv
module tb_argmax_tracker;
  localparam int DW = 16;
  localparam int NC = 10;
  localparam int IW = $clog2(NC);
  localparam int CW = $clog2(NC + 1);
  localparam int RW = IW + DW + 1 + CW;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready, in_last, out_valid, out_ready, out_tie;
  logic [DW-1:0] in_data, out_max;
  logic [IW-1:0] out_idx;
  logic [CW-1:0] out_count;
  logic [RW-1:0] got;
  logic          pre_ov;
  logic [DW-1:0] frm[$];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  argmax_tracker #(.DATA_W(DW), .NUM_CLASS(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_max   (out_max),
    .out_tie   (out_tie),
    .out_count (out_count)
  );

  assign got = {out_idx, out_max, out_tie, out_count};

  function automatic bit greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic [RW-1:0] model();
    int best = 0;
    bit tie  = 1'b0;
    for (int i = 1; i < frm.size(); i++) if (greater(frm[i], frm[best])) best = i;
    for (int j = best + 1; j < frm.size(); j++) if (frm[j] == frm[best]) tie = 1'b1;
    return {IW'(best), frm[best], tie, CW'(frm.size())};
  endfunction

  task automatic send(input logic [DW-1:0] d, input bit last, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    pre_ov = out_valid;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    frm.push_back(d);
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, got} !== {1'b0, 1'b1, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL reset: got ov=%b rdy=%b res=%h expected ov=0 rdy=1 res=0", out_valid, in_ready, got);
    end
  endtask

  task automatic test_basic();
    int v[10];
    v = '{3, 9, 2, 7, 1, 0, 4, 5, 8, 6};
    frm.delete();
    foreach (v[i]) send(DW'(v[i]), i == 9, 0);
    checks++;
    if (pre_ov !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got pre=%b ov=%b expected pre=0 ov=1", pre_ov, out_valid);
    end
    checks++;
    if (got !== model()) begin
      errors++;
      $display("FAIL basic_result: got %h expected %h", got, model());
    end
    checks++;
    if (got !== {IW'(1), DW'(9), 1'b0, CW'(10)}) begin
      errors++;
      $display("FAIL basic_const: got %h expected %h", got, {IW'(1), DW'(9), 1'b0, CW'(10)});
    end
    release_res();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: got ov=%b rdy=%b expected ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_tie_hold();
    logic [RW-1:0] exp;
    frm.delete();
    send(5, 0, 0); send(12, 0, 0); send(12, 0, 0); send(4, 1, 0);
    exp = model();
    in_valid = 1'b1; in_data = 16'd99;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (got !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL tie_hold[%0d]: got res=%h ov=%b rdy=%b expected res=%h ov=1 rdy=0",
                 k, got, out_valid, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== {IW'(1), DW'(12), 1'b1, CW'(4)}) begin
      errors++;
      $display("FAIL tie_const: got %h expected %h", got, {IW'(1), DW'(12), 1'b1, CW'(4)});
    end
    release_res();
  endtask

  task automatic test_auto_term();
    frm.delete();
    for (int i = 0; i < NC; i++) send(16'h0007, 0, 0);
    checks++;
    if (pre_ov !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL auto_term_valid: got pre=%b ov=%b expected pre=0 ov=1", pre_ov, out_valid);
    end
    checks++;
    if (got !== model()) begin
      errors++;
      $display("FAIL auto_term_result: got %h expected %h", got, model());
    end
    release_res();
  endtask

  task automatic test_back_to_back();
    frm.delete();
    send(1, 0, 2); send(20, 0, 3); send(3, 1, 1);
    checks++;
    if (got !== model() || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL gaps_result: got %h ov=%b expected %h ov=1", got, out_valid, model());
    end
    release_res();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b expected 1", in_ready);
    end
    frm.delete();
    send(30, 1, 0);
    checks++;
    if (got !== model() || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result: got %h ov=%b expected %h ov=1", got, out_valid, model());
    end
    release_res();
  endtask

  task automatic test_clear();
    frm.delete();
    send(8, 0, 0); send(9, 0, 0);
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    frm.delete();
    send(2, 0, 0); send(1, 1, 0);
    checks++;
    if (got !== model() || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_accum: got %h ov=%b expected %h ov=1", got, out_valid, model());
    end
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_done: got ov=%b rdy=%b expected ov=0 rdy=1", out_valid, in_ready);
    end
    frm.delete();
    send(4, 1, 0);
    checks++;
    if (got !== model()) begin
      errors++;
      $display("FAIL clear_next: got %h expected %h", got, model());
    end
    release_res();
  endtask

  task automatic test_rst_mid();
    frm.delete();
    send(5, 0, 0); send(6, 0, 0); send(7, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, got} !== {1'b0, 1'b1, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL rst_accum: got ov=%b rdy=%b res=%h expected ov=0 rdy=1 res=0", out_valid, in_ready, got);
    end
    @(posedge clk); #1 rst = 1'b0;
    frm.delete();
    send(3, 1, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, got} !== {1'b0, 1'b1, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL rst_done: got ov=%b rdy=%b res=%h expected ov=0 rdy=1 res=0", out_valid, in_ready, got);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_signed();
    logic [RW-1:0] exp;
`ifdef ARGMAX_SIGNED_EN
    exp = {IW'(1), 16'h0001, 1'b0, CW'(2)};
`else
    exp = {IW'(0), 16'hFFFF, 1'b0, CW'(2)};
`endif
    frm.delete();
    send(16'hFFFF, 0, 0); send(16'h0001, 1, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL signedness: got %h expected %h", got, exp);
    end
    release_res();
  endtask

  task automatic test_random();
    logic [RW-1:0] exp;
    int len, hold;
    bit last;
    for (int f = 0; f < 40; f++) begin
      frm.delete();
      len = $urandom_range(1, NC);
      for (int i = 0; i < len; i++) begin
        last = (i == len - 1) ? ((len < NC) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        send($urandom_range(0, 1) ? DW'($urandom_range(0, 5)) : DW'($urandom),
             last, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      exp = model();
      checks++;
      if (pre_ov !== 1'b0 || out_valid !== 1'b1 || got !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got pre=%b ov=%b res=%h expected pre=0 ov=1 res=%h",
                 f, pre_ov, out_valid, got, exp);
      end
      hold = $urandom_range(0, 3);
      repeat (hold) begin @(posedge clk); #1; end
      checks++;
      if (got !== exp || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL random_hold[%0d]: got res=%h ov=%b expected res=%h ov=1", f, got, out_valid, exp);
      end
      release_res();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_tie_hold();
    test_auto_term();
    test_back_to_back();
    test_clear();
    test_rst_mid();
    test_signed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
